// File: rtl/battleship_turn_controller_if.sv
// Board/shot/display signal bundle between the keyboard/VGA side and the
// turn controller. The master drives requests; the slave is the controller.
interface battleship_turn_controller_if #(
   parameter int BOARD_SIZE = 10
);
   localparam int W = 2 * BOARD_SIZE;

   logic          load_en;
   logic          load_player;
   logic [3:0]    load_row;
   logic [W-1:0]  load_data;
   logic          start;
   logic          shot_valid;
   logic [3:0]    shot_row;
   logic [3:0]    shot_col;
   logic          shot_ready;
   logic          result_valid;
   logic [1:0]    result_code;
   logic          player_turn;
   logic          game_over;
   logic          winner;
   logic [4:0]    remaining0;
   logic [4:0]    remaining1;
   logic          disp_player;
   logic [3:0]    disp_row;
   logic [W-1:0]  disp_data;

   modport master (
      output load_en, load_player, load_row, load_data, start,
             shot_valid, shot_row, shot_col, disp_player, disp_row,
      input  shot_ready, result_valid, result_code, player_turn,
             game_over, winner, remaining0, remaining1, disp_data
   );

   modport slave (
      input  load_en, load_player, load_row, load_data, start,
             shot_valid, shot_row, shot_col, disp_player, disp_row,
      output shot_ready, result_valid, result_code, player_turn,
             game_over, winner, remaining0, remaining1, disp_data
   );
endinterface

// File: rtl/battleship_turn_controller.sv
// Battleship turn controller: holds both boards, resolves shots on the
// opponent's board, alternates turns and declares the winner.
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_IDLE    | boards loadable, waiting for start
// S_PLAY    | shot_ready high, waiting for a shot request
// S_READ    | fetch target row and extract the addressed cell
// S_RESOLVE | classify shot, update board/counters/turn, pulse result
// S_OVER    | game finished, everything frozen until start
module battleship_turn_controller #(
   parameter int BOARD_SIZE = 10,
   parameter int SHIP_CELLS = 17
) (
   input  logic                        i_clock50,
   input  logic                        i_reset,
   battleship_turn_controller_if.slave bus
);
   localparam int         W        = 2 * BOARD_SIZE;
   localparam logic [3:0] LP_N     = 4'(BOARD_SIZE);
   localparam logic [4:0] LP_SHIPS = 5'(SHIP_CELLS);

   typedef enum logic [2:0] {S_IDLE, S_PLAY, S_READ, S_RESOLVE, S_OVER} state_t;

   state_t        r_state, w_next;
   logic [W-1:0]  r_board [2][BOARD_SIZE];
   logic [3:0]    r_shot_row, r_shot_col;
   logic          r_bad, r_target;
   logic [1:0]    r_cell;
   logic          r_turn, r_winner, r_result_valid;
   logic [1:0]    r_result_code;
   logic [4:0]    r_rem [2];
   logic [W-1:0]  r_disp;
   logic [4:0]    w_shift;
   logic [4:0]    w_rem_tgt;
   logic          w_accept, w_is_hit, w_last_hit, w_bad_in;
   logic          w_shot_ready, w_game_over;

   // Column 0 is the MSB pair of a row.
   assign w_shift    = 5'(W - 2) - {r_shot_col, 1'b0};
   assign w_accept   = (r_state == S_PLAY) && bus.shot_valid;
   assign w_bad_in   = (bus.shot_row >= LP_N) || (bus.shot_col >= LP_N);
   assign w_rem_tgt  = r_rem[r_target];
   assign w_is_hit   = !r_bad && (r_cell == 2'b01);
   assign w_last_hit = (w_rem_tgt <= 5'd1);

   // State register.
   always_ff @(posedge i_clock50 or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      w_next       = r_state;
      w_shot_ready = 1'b0;
      w_game_over  = 1'b0;
      unique case (r_state)
         S_IDLE:    if (bus.start) w_next = S_PLAY;
         S_PLAY: begin
            w_shot_ready = 1'b1;
            if (bus.shot_valid) w_next = S_READ;
         end
         S_READ:    w_next = S_RESOLVE;
         S_RESOLVE: w_next = (w_is_hit && w_last_hit) ? S_OVER : S_PLAY;
         S_OVER: begin
            w_game_over = 1'b1;
            if (bus.start) w_next = S_IDLE;
         end
         default:   w_next = S_IDLE;
      endcase
   end

   // Board storage: row loads in IDLE, cell marking in RESOLVE (00->10, 01->11).
   always_ff @(posedge i_clock50 or posedge i_reset) begin
      if (i_reset) begin
         for (int p = 0; p < 2; p++)
            for (int r = 0; r < BOARD_SIZE; r++)
               r_board[p][r] <= '0;
      end else if (r_state == S_IDLE && bus.load_en && bus.load_row < LP_N) begin
         r_board[bus.load_player][bus.load_row] <= bus.load_data;
      end else if (r_state == S_RESOLVE && !r_bad && !r_cell[1]) begin
         r_board[r_target][r_shot_row][w_shift +: 2] <= {1'b1, r_cell[0]};
      end
   end

   // Shot latch and cell fetch; bad coordinates are clamped so indexing stays in range.
   always_ff @(posedge i_clock50 or posedge i_reset) begin
      if (i_reset) begin
         r_shot_row <= '0;
         r_shot_col <= '0;
         r_bad      <= 1'b0;
         r_target   <= 1'b0;
         r_cell     <= 2'b00;
      end else begin
         if (w_accept) begin
            r_bad      <= w_bad_in;
            r_shot_row <= w_bad_in ? 4'd0 : bus.shot_row;
            r_shot_col <= w_bad_in ? 4'd0 : bus.shot_col;
            r_target   <= !r_turn;
         end
         if (r_state == S_READ) r_cell <= r_board[r_target][r_shot_row][w_shift +: 2];
      end
   end

   // Game bookkeeping: turn, counters, winner and the result pulse.
   always_ff @(posedge i_clock50 or posedge i_reset) begin
      if (i_reset) begin
         r_turn         <= 1'b0;
         r_winner       <= 1'b0;
         r_result_valid <= 1'b0;
         r_result_code  <= 2'b00;
         r_rem[0]       <= LP_SHIPS;
         r_rem[1]       <= LP_SHIPS;
      end else begin
         r_result_valid <= (r_state == S_RESOLVE);
         if (r_state == S_IDLE && bus.start) begin
            r_turn   <= 1'b0;
            r_rem[0] <= LP_SHIPS;
            r_rem[1] <= LP_SHIPS;
         end
         if (r_state == S_RESOLVE) begin
            if (r_bad) begin
               r_result_code <= 2'b10;
            end else if (r_cell[1]) begin
               r_result_code <= 2'b11;
            end else if (!r_cell[0]) begin
               r_result_code <= 2'b00;
               r_turn        <= !r_turn;
            end else begin
               r_result_code <= 2'b01;
               if (w_rem_tgt != 5'd0) r_rem[r_target] <= w_rem_tgt - 5'd1;
               if (w_last_hit) r_winner <= r_turn;
               else            r_turn   <= !r_turn;
            end
         end
      end
   end

   // Registered display read port, live in every state.
   always_ff @(posedge i_clock50 or posedge i_reset) begin
      if (i_reset)                  r_disp <= '0;
      else if (bus.disp_row < LP_N) r_disp <= r_board[bus.disp_player][bus.disp_row];
      else                          r_disp <= '0;
   end

   assign bus.shot_ready   = w_shot_ready;
   assign bus.game_over    = w_game_over;
   assign bus.result_valid = r_result_valid;
   assign bus.result_code  = r_result_code;
   assign bus.player_turn  = r_turn;
   assign bus.winner       = r_winner;
   assign bus.remaining0   = r_rem[0];
   assign bus.remaining1   = r_rem[1];
   assign bus.disp_data    = r_disp;
endmodule

// File: tb/tb_battleship_turn_controller.sv
// Testbench for battleship_turn_controller: directed scenarios plus a random
// full game, checked against a cell-level game model.
module tb_battleship_turn_controller;
   localparam int BS = 10;
   localparam int SC = 17;

   logic clock50 = 1'b0;
   logic reset;
   always #5 clock50 = ~clock50;

   battleship_turn_controller_if bus ();

   battleship_turn_controller #(.BOARD_SIZE(BS), .SHIP_CELLS(SC)) dut (
      .i_clock50 (clock50),
      .i_reset   (reset),
      .bus       (bus)
   );

   // Reference model: cells 0 water, 1 ship, 2 miss, 3 hit; mode 0 idle, 1 play, 2 over.
   int m_cell [2][BS][BS];
   int m_turn, m_winner, m_mode;
   int m_rem [2];
   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int p = 0; p < 2; p++)
         for (int r = 0; r < BS; r++)
            for (int c = 0; c < BS; c++) m_cell[p][r][c] = 0;
      m_turn = 0; m_winner = 0; m_mode = 0;
      m_rem[0] = SC; m_rem[1] = SC;
   endfunction

   function automatic logic [19:0] m_row(input int p, input int r);
      logic [19:0] v;
      v = '0;
      if (r >= BS) return v;
      for (int c = 0; c < BS; c++) v = v | (20'(m_cell[p][r][c]) << (2 * (BS - 1 - c)));
      return v;
   endfunction

   function automatic void model_start();
      if (m_mode == 0) begin
         m_mode = 1; m_turn = 0; m_rem[0] = SC; m_rem[1] = SC;
      end else if (m_mode == 2) begin
         m_mode = 0;
      end
   endfunction

   function automatic int model_shot(input int r, input int c);
      int t;
      t = 1 - m_turn;
      if (r >= BS || c >= BS) return 2;
      if (m_cell[t][r][c] >= 2) return 3;
      if (m_cell[t][r][c] == 0) begin
         m_cell[t][r][c] = 2;
         m_turn = 1 - m_turn;
         return 0;
      end
      m_cell[t][r][c] = 3;
      if (m_rem[t] > 0) m_rem[t] = m_rem[t] - 1;
      if (m_rem[t] == 0) begin
         m_mode = 2; m_winner = m_turn;
      end else begin
         m_turn = 1 - m_turn;
      end
      return 1;
   endfunction

   task automatic tick();
      @(posedge clock50);
      #1;
   endtask

   task automatic idle_inputs();
      bus.load_en = 1'b0; bus.load_player = 1'b0; bus.load_row = 4'd0; bus.load_data = '0;
      bus.start = 1'b0; bus.shot_valid = 1'b0; bus.shot_row = 4'd0; bus.shot_col = 4'd0;
      bus.disp_player = 1'b0; bus.disp_row = 4'd0;
   endtask

   task automatic do_load(input int p, input int r, input logic [19:0] d, input bit with_start);
      bus.load_en = 1'b1; bus.load_player = p[0]; bus.load_row = r[3:0]; bus.load_data = d;
      bus.start = with_start;
      tick();
      bus.load_en = 1'b0; bus.start = 1'b0;
      if (m_mode == 0 && r < BS)
         for (int c = 0; c < BS; c++) m_cell[p][r][c] = int'((d >> (2 * (BS - 1 - c))) & 20'h3);
      if (with_start) model_start();
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      model_start();
   endtask

   task automatic check_row(input int p, input int r);
      bus.disp_player = p[0]; bus.disp_row = r[3:0];
      tick();
      chk_eq("disp_row", 32'(bus.disp_data), 32'(m_row(p, r)));
   endtask

   task automatic check_all();
      for (int p = 0; p < 2; p++)
         for (int r = 0; r < BS; r++) check_row(p, r);
   endtask

   task automatic check_status();
      chk_eq("turn", 32'(bus.player_turn), m_turn);
      chk_eq("rem0", 32'(bus.remaining0), m_rem[0]);
      chk_eq("rem1", 32'(bus.remaining1), m_rem[1]);
      chk_eq("game_over", 32'(bus.game_over), (m_mode == 2) ? 1 : 0);
      chk_eq("shot_ready", 32'(bus.shot_ready), (m_mode == 1) ? 1 : 0);
      if (m_mode == 2) chk_eq("winner", 32'(bus.winner), m_winner);
   endtask

   // One shot request; with hold the request line stays high (junk coords) while busy.
   task automatic fire(input int r, input int c, input bit hold);
      int          code, tgt, dr;
      bit          acc;
      logic [19:0] old_row;
      acc = (m_mode == 1);
      tgt = 1 - m_turn;
      dr  = (r < BS) ? r : 0;
      old_row = m_row(tgt, dr);
      bus.disp_player = tgt[0]; bus.disp_row = dr[3:0];
      bus.shot_valid = 1'b1; bus.shot_row = r[3:0]; bus.shot_col = c[3:0];
      tick();
      bus.shot_valid = hold; bus.shot_row = 4'($urandom); bus.shot_col = 4'($urandom);
      chk_eq("ready_busy", 32'(bus.shot_ready), 0);
      tick();
      chk_eq("rv_early", 32'(bus.result_valid), 0);
      tick();
      if (acc) begin
         code = model_shot(r, c);
         chk_eq("rv_pulse", 32'(bus.result_valid), 1);
         chk_eq("code", 32'(bus.result_code), code);
         chk_eq("disp_old", 32'(bus.disp_data), 32'(old_row));
      end else begin
         chk_eq("rv_ignored", 32'(bus.result_valid), 0);
      end
      check_status();
   endtask

   task automatic random_ships();
      int cnt, r, c;
      for (int p = 0; p < 2; p++) begin
         cnt = 0;
         while (cnt < SC) begin
            r = $urandom_range(BS - 1, 0);
            c = $urandom_range(BS - 1, 0);
            if (m_cell[p][r][c] == 0) begin
               m_cell[p][r][c] = 1;
               cnt++;
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, c, t, k0, idx;
      logic [19:0] rows_p0 [BS];
      logic [19:0] rows_p1 [BS];
      reset = 1'b1;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clock50);
      #1 reset = 1'b0;
      chk_eq("rst_rv", 32'(bus.result_valid), 0);
      chk_eq("rst_code", 32'(bus.result_code), 0);
      chk_eq("rst_disp", 32'(bus.disp_data), 0);
      chk_eq("rst_winner", 32'(bus.winner), 0);
      check_status();

      // Reset during READ discards the shot.
      do_load(0, 4, 20'h00300, 0);
      do_load(1, 4, 20'h00100, 1);
      bus.shot_valid = 1'b1; bus.shot_row = 4'd4; bus.shot_col = 4'd4;
      tick();
      bus.shot_valid = 1'b0;
      #3 reset = 1'b1;
      model_reset();
      #1;
      chk_eq("mid_rst_disp", 32'(bus.disp_data), 0);
      check_status();
      tick();
      #2 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_eq("no_pulse", 32'(bus.result_valid), 0);
      end
      check_all();
      check_status();

      // Directed: load, load+start together, hits, misses, repeats, bad coordinates.
      do_load(1, 0, 20'h00001, 0);
      do_load(0, 12, 20'hABCDE, 0);
      do_load(0, 3, 20'h01000, 1);
      check_status();
      fire(0, 9, 0);
      check_row(1, 0);
      fire(3, 3, 0);
      fire(5, 0, 0);
      fire(5, 0, 0);
      fire(5, 0, 0);
      check_row(1, 5);
      fire(10, 3, 0);
      fire(2, 12, 0);
      fire(15, 15, 0);
      check_row(0, 2);
      check_row(0, 12);

      // Loads and start are ignored during play.
      do_load(1, 0, 20'hFFFFF, 0);
      check_row(1, 0);
      pulse_start();
      check_status();

      // Back-to-back requests with shot_valid held high.
      for (int i = 0; i < 9; i++)
         fire($urandom_range(11, 0), $urandom_range(11, 0), (i != 8));

      // Random full game.
      reset = 1'b1;
      model_reset();
      tick();
      reset = 1'b0;
      random_ships();
      for (int rr = 0; rr < BS; rr++) begin
         rows_p0[rr] = m_row(0, rr);
         rows_p1[rr] = m_row(1, rr);
      end
      for (int rr = 0; rr < BS; rr++) do_load(0, rr, rows_p0[rr], 0);
      for (int rr = 0; rr < BS; rr++) do_load(1, rr, rows_p1[rr], 0);
      check_all();
      pulse_start();
      for (int i = 0; i < 1500 && m_mode == 1; i++) begin
         t = 1 - m_turn;
         if ($urandom_range(9, 0) == 0) begin
            r = $urandom_range(15, 0); c = $urandom_range(15, 0);
         end else if ($urandom_range(9, 0) < 7) begin
            k0 = $urandom_range(BS * BS - 1, 0);
            r = k0 / BS; c = k0 % BS;
            for (int k = 0; k < BS * BS; k++) begin
               idx = (k0 + k) % (BS * BS);
               if (m_cell[t][idx / BS][idx % BS] < 2) begin
                  r = idx / BS; c = idx % BS;
                  break;
               end
            end
         end else begin
            r = $urandom_range(BS - 1, 0); c = $urandom_range(BS - 1, 0);
         end
         fire(r, c, 1'($urandom_range(1, 0)));
      end
      bus.shot_valid = 1'b0;
      tick();
      chk_eq("final_over", 32'(bus.game_over), 1);
      check_status();

      // Frozen after game over, then start returns to idle with boards kept.
      fire(3, 3, 0);
      fire(0, 0, 0);
      pulse_start();
      check_status();
      chk_eq("idle_over", 32'(bus.game_over), 0);
      check_all();
      do_load(0, 1, 20'h55555, 0);
      check_row(0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
